// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcodes, the decoded control word, and halt sequencing states.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef struct packed {
    aluop_t aluop;
    logic   RegDst;
    logic   RegWr;
    logic   ImmToReg;
    logic   DataRead;
    logic   DataWrite;
    logic   ShamToAlu;
    logic   ImmToAlu;
    logic   BrEq;
    logic   BrNeq;
    logic   Jump;
    logic   Jal;
    logic   Jr;
    logic   ExtOp;
    logic   Halt;
    logic   LinkedLoad;
    logic   StoreConditional;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  localparam logic [4:0] REG_RA = 5'd31;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic sign_ext);
    extend_imm = sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/id_ex_latch_hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_data_read,
  input  logic [4:0] ex_wsel,
  input  logic       id_valid,
  input  logic       id_imm_to_alu,
  input  logic       id_data_write,
  input  logic       id_br_eq,
  input  logic       id_br_neq,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       flush,
  input  logic       run,
  output logic       load_use,
  output logic       stall_id
);

  logic uses_rt;

  always_comb begin
    // rt is a source for R-type ALU ops, stores (data) and branches (compare)
    uses_rt  = id_valid & (~id_imm_to_alu | id_data_write | id_br_eq | id_br_neq);
    load_use = ex_valid & ex_data_read & (ex_wsel != 5'd0) &
               ((ex_wsel == id_rs) | ((ex_wsel == id_rt) & uses_rt));
    stall_id = id_valid & load_use & run & ~flush;
  end

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use bubble insertion and halt drain sequencing.
module id_ex_latch
  import cpu_types_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        en,
  input  logic        flush,
  input  logic        id_valid,
  input  ctrl_t       id_ctrl,
  input  logic [31:0] id_pc4,
  input  logic [31:0] id_rdat1,
  input  logic [31:0] id_rdat2,
  input  logic [15:0] id_imm16,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_shamt,
  output logic        ex_valid,
  output ctrl_t       ex_ctrl,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_rdat1,
  output logic [31:0] ex_rdat2,
  output logic [31:0] ex_imm32,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_wsel,
  output logic        stall_id,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

  logic          valid_q, valid_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [31:0]   pc4_q, pc4_d;
  logic [31:0]   rdat1_q, rdat1_d;
  logic [31:0]   rdat2_q, rdat2_d;
  logic [31:0]   imm32_q, imm32_d;
  logic [4:0]    shamt_q, shamt_d;
  logic [4:0]    rs_q, rs_d;
  logic [4:0]    rt_q, rt_d;
  logic [4:0]    wsel_q, wsel_d;
  logic          halted_q, halted_d;
  halt_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic load_use;
  logic capture;

  hazard_detect u_hazard (
    .ex_valid      (valid_q),
    .ex_data_read  (ctrl_q.DataRead),
    .ex_wsel       (wsel_q),
    .id_valid      (id_valid),
    .id_imm_to_alu (id_ctrl.ImmToAlu),
    .id_data_write (id_ctrl.DataWrite),
    .id_br_eq      (id_ctrl.BrEq),
    .id_br_neq     (id_ctrl.BrNeq),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .flush         (flush),
    .run           (state_q == RUN),
    .load_use      (load_use),
    .stall_id      (stall_id)
  );

  assign capture = en & ~flush & id_valid & ~load_use & (state_q == RUN);

  // Datapath register next-state
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc4_d   = pc4_q;
    rdat1_d = rdat1_q;
    rdat2_d = rdat2_q;
    imm32_d = imm32_q;
    shamt_d = shamt_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wsel_d  = wsel_q;
    if (capture) begin
      valid_d = 1'b1;
      ctrl_d  = id_ctrl;
      pc4_d   = id_pc4;
      rdat1_d = id_rdat1;
      rdat2_d = id_rdat2;
      imm32_d = extend_imm(id_imm16, id_ctrl.ExtOp);
      shamt_d = id_shamt;
      rs_d    = id_rs;
      rt_d    = id_rt;
      wsel_d  = id_ctrl.Jal ? REG_RA : (id_ctrl.RegDst ? id_rd : id_rt);
    end else if (en) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      pc4_d   = '0;
      rdat1_d = '0;
      rdat2_d = '0;
      imm32_d = '0;
      shamt_d = '0;
      rs_d    = '0;
      rt_d    = '0;
      wsel_d  = '0;
    end
  end

  // Halt FSM next-state; the counter only moves on advancing cycles
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    if (en) begin
      case (state_q)
        RUN: begin
          if (capture && id_ctrl.Halt) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HALTED: begin
          halted_d = 1'b1;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      pc4_q    <= '0;
      rdat1_q  <= '0;
      rdat2_q  <= '0;
      imm32_q  <= '0;
      shamt_q  <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      wsel_q   <= '0;
      halted_q <= 1'b0;
      state_q  <= RUN;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      pc4_q    <= pc4_d;
      rdat1_q  <= rdat1_d;
      rdat2_q  <= rdat2_d;
      imm32_q  <= imm32_d;
      shamt_q  <= shamt_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      wsel_q   <= wsel_d;
      halted_q <= halted_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_valid  = valid_q;
  assign ex_ctrl   = ctrl_q;
  assign ex_pc4    = pc4_q;
  assign ex_rdat1  = rdat1_q;
  assign ex_rdat2  = rdat2_q;
  assign ex_imm32  = imm32_q;
  assign ex_shamt  = shamt_q;
  assign ex_rs     = rs_q;
  assign ex_rt     = rt_q;
  assign ex_wsel   = wsel_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;

endmodule
